// File: rtl/i2s_clkws_pkg.sv
// Shared types, default widths and helpers for the multi-source I2S SCK/WS generator.
package i2s_clkws_pkg;

  typedef enum logic [1:0] {
    WS_WORD = 2'b00,
    WS_TDM  = 2'b01
  } ws_mode_e;

  localparam int DEF_DIV_W  = 16;
  localparam int DEF_SIZE_W = 5;
  localparam int DEF_NUM_W  = 3;

  // Source-select width: wide enough to index any generator or pad pair, never zero.
  function automatic int sel_w(input int num_gen, input int num_port);
    int m;
    m = (num_gen > num_port) ? num_gen : num_port;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/i2s_sck_ws_core.sv
// One divider-based SCK/WS generator: half-period divider, bit/word counters,
// WORD or TDM word-select and a frame-start strobe, all registered in clk_sys.
module i2s_sck_ws_core
  import i2s_clkws_pkg::*;
#(
  parameter int DIV_W  = DEF_DIV_W,
  parameter int SIZE_W = DEF_SIZE_W,
  parameter int NUM_W  = DEF_NUM_W
) (
  input  logic              clk_sys,
  input  logic              rst_b,
  input  logic              active,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [SIZE_W-1:0] cfg_size,
  input  logic [NUM_W-1:0]  cfg_num,
  input  logic [1:0]        cfg_ws_mode,
  output logic              sck,
  output logic              ws,
  output logic              rise,
  output logic              fall,
  output logic              frame_start
);

  logic              running;
  logic [DIV_W-1:0]  cnt;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_eff;
  logic [SIZE_W-1:0] bit_cnt;
  logic [SIZE_W-1:0] size_q;
  logic [SIZE_W-1:0] size_eff;
  logic [SIZE_W-1:0] bit_nxt;
  logic [NUM_W-1:0]  word_cnt;
  logic [NUM_W-1:0]  num_q;
  logic [NUM_W-1:0]  num_eff;
  logic [NUM_W-1:0]  word_nxt;
  logic              wrap;
  logic              bit_wrap;
  logic              word_wrap;
  logic              frame_wrap;
  logic              last_bit;

  // Until the first active cycle has latched the config, use the live inputs so
  // that the first half-period after (re)enable is already div+1 cycles long.
  always_comb begin
    div_eff    = running ? div_q  : cfg_div;
    size_eff   = running ? size_q : cfg_size;
    num_eff    = running ? num_q  : cfg_num;
    wrap       = (cnt == div_eff);
    bit_wrap   = (bit_cnt == size_eff);
    word_wrap  = (word_cnt == num_eff);
    frame_wrap = bit_wrap & word_wrap;
    bit_nxt    = bit_wrap ? '0 : bit_cnt + 1'b1;
    word_nxt   = word_cnt;
    if (bit_wrap) begin
      word_nxt = word_wrap ? '0 : word_cnt + 1'b1;
    end
    last_bit   = (bit_nxt == size_eff) && (word_nxt == num_eff);
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b || !active) begin
      running     <= 1'b0;
      cnt         <= '0;
      div_q       <= '0;
      size_q      <= '0;
      num_q       <= '0;
      bit_cnt     <= '0;
      word_cnt    <= '0;
      sck         <= 1'b0;
      ws          <= 1'b0;
      rise        <= 1'b0;
      fall        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      running     <= 1'b1;
      rise        <= 1'b0;
      fall        <= 1'b0;
      frame_start <= 1'b0;
      if (!running) begin
        div_q  <= cfg_div;
        size_q <= cfg_size;
        num_q  <= cfg_num;
      end
      if (wrap) begin
        cnt   <= '0;
        sck   <= ~sck;
        div_q <= cfg_div;
        rise  <= ~sck;
        fall  <= sck;
        if (sck) begin
          bit_cnt     <= bit_nxt;
          word_cnt    <= word_nxt;
          frame_start <= frame_wrap;
          if (frame_wrap) begin
            size_q <= cfg_size;
            num_q  <= cfg_num;
          end
          // Reserved modes fall back to per-word toggling.
          if (cfg_ws_mode == WS_TDM) begin
            ws <= last_bit;
          end else if (bit_wrap) begin
            ws <= ~ws;
          end
        end
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2s_clkws_gen_multi.sv
// NUM_GEN internal SCK/WS generators and NUM_PORT I2S ports; each port registers
// either a generator or a synchronised pad pair. No clocks are gated or muxed.
module i2s_clkws_gen_multi
  import i2s_clkws_pkg::*;
#(
  parameter int NUM_GEN     = 2,
  parameter int NUM_PORT    = 2,
  parameter int DIV_W       = DEF_DIV_W,
  parameter int SIZE_W      = DEF_SIZE_W,
  parameter int NUM_W       = DEF_NUM_W,
  parameter int SYNC_STAGES = 2,
  parameter int SEL_W       = sel_w(NUM_GEN, NUM_PORT)
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic [NUM_GEN-1:0]         cfg_en_i,
  input  logic [NUM_GEN*DIV_W-1:0]   cfg_div_i,
  input  logic [NUM_GEN*SIZE_W-1:0]  cfg_word_size_i,
  input  logic [NUM_GEN*NUM_W-1:0]   cfg_word_num_i,
  input  logic [NUM_GEN*2-1:0]       cfg_ws_mode_i,
  input  logic [NUM_PORT-1:0]        port_en_i,
  input  logic [NUM_PORT*SEL_W-1:0]  port_sel_num_i,
  input  logic [NUM_PORT-1:0]        port_sel_ext_i,
  input  logic [NUM_PORT-1:0]        pad_sck_i,
  input  logic [NUM_PORT-1:0]        pad_ws_i,
  output logic [NUM_PORT-1:0]        pad_sck_o,
  output logic [NUM_PORT-1:0]        pad_ws_o,
  output logic [NUM_PORT-1:0]        pad_oe_o,
  output logic [NUM_PORT-1:0]        port_sck_o,
  output logic [NUM_PORT-1:0]        port_ws_o,
  output logic [NUM_PORT-1:0]        port_rise_o,
  output logic [NUM_PORT-1:0]        port_fall_o,
  output logic [NUM_GEN-1:0]         gen_frame_start_o
);

  logic [NUM_GEN-1:0]                    gen_active;
  logic [NUM_GEN-1:0]                    gen_sck;
  logic [NUM_GEN-1:0]                    gen_ws;
  logic [NUM_GEN-1:0]                    gen_rise;
  logic [NUM_GEN-1:0]                    gen_fall;
  logic [NUM_PORT-1:0][SYNC_STAGES-1:0]  sck_sr;
  logic [NUM_PORT-1:0][SYNC_STAGES-1:0]  ws_sr;
  logic [NUM_PORT-1:0]                   sck_hist;
  logic [NUM_PORT-1:0]                   ext_sck;
  logic [NUM_PORT-1:0]                   ext_ws;
  logic [NUM_PORT-1:0]                   ext_rise;
  logic [NUM_PORT-1:0]                   ext_fall;
  logic [NUM_PORT-1:0]                   mux_sck;
  logic [NUM_PORT-1:0]                   mux_ws;
  logic [NUM_PORT-1:0]                   mux_rise;
  logic [NUM_PORT-1:0]                   mux_fall;

  // A generator only runs while some enabled internal port is listening to it.
  always_comb begin
    gen_active = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      for (int g = 0; g < NUM_GEN; g++) begin
        if (port_en_i[p] && !port_sel_ext_i[p] &&
            (port_sel_num_i[p*SEL_W +: SEL_W] == SEL_W'(g))) begin
          gen_active[g] = 1'b1;
        end
      end
    end
    gen_active = gen_active & cfg_en_i;
  end

  for (genvar g = 0; g < NUM_GEN; g++) begin : g_core
    i2s_sck_ws_core #(
      .DIV_W  (DIV_W),
      .SIZE_W (SIZE_W),
      .NUM_W  (NUM_W)
    ) u_core (
      .clk_sys     (clk_i),
      .rst_b       (rstn_i),
      .active      (gen_active[g]),
      .cfg_div     (cfg_div_i[g*DIV_W +: DIV_W]),
      .cfg_size    (cfg_word_size_i[g*SIZE_W +: SIZE_W]),
      .cfg_num     (cfg_word_num_i[g*NUM_W +: NUM_W]),
      .cfg_ws_mode (cfg_ws_mode_i[g*2 +: 2]),
      .sck         (gen_sck[g]),
      .ws          (gen_ws[g]),
      .rise        (gen_rise[g]),
      .fall        (gen_fall[g]),
      .frame_start (gen_frame_start_o[g])
    );
  end

  // WS uses the same synchroniser depth as SCK so their relative timing survives.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sck_sr   <= '0;
      ws_sr    <= '0;
      sck_hist <= '0;
    end else begin
      for (int p = 0; p < NUM_PORT; p++) begin
        sck_sr[p]   <= {sck_sr[p][SYNC_STAGES-2:0], pad_sck_i[p]};
        ws_sr[p]    <= {ws_sr[p][SYNC_STAGES-2:0], pad_ws_i[p]};
        sck_hist[p] <= sck_sr[p][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORT; p++) begin
      ext_sck[p] = sck_sr[p][SYNC_STAGES-1];
      ext_ws[p]  = ws_sr[p][SYNC_STAGES-1];
    end
    ext_rise = ext_sck & ~sck_hist;
    ext_fall = ~ext_sck & sck_hist;
  end

  // Select that matches no source leaves the port at 0.
  always_comb begin
    mux_sck  = '0;
    mux_ws   = '0;
    mux_rise = '0;
    mux_fall = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (!port_sel_ext_i[p]) begin
        for (int g = 0; g < NUM_GEN; g++) begin
          if (port_sel_num_i[p*SEL_W +: SEL_W] == SEL_W'(g)) begin
            mux_sck[p]  = gen_sck[g];
            mux_ws[p]   = gen_ws[g];
            mux_rise[p] = gen_rise[g];
            mux_fall[p] = gen_fall[g];
          end
        end
      end else begin
        for (int q = 0; q < NUM_PORT; q++) begin
          if (port_sel_num_i[p*SEL_W +: SEL_W] == SEL_W'(q)) begin
            mux_sck[p]  = ext_sck[q];
            mux_ws[p]   = ext_ws[q];
            mux_rise[p] = ext_rise[q];
            mux_fall[p] = ext_fall[q];
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      port_sck_o  <= '0;
      port_ws_o   <= '0;
      port_rise_o <= '0;
      port_fall_o <= '0;
      pad_oe_o    <= '0;
    end else begin
      port_sck_o  <= port_en_i & mux_sck;
      port_ws_o   <= port_en_i & mux_ws;
      port_rise_o <= port_en_i & mux_rise;
      port_fall_o <= port_en_i & mux_fall;
      pad_oe_o    <= port_en_i & ~port_sel_ext_i;
    end
  end

  assign pad_sck_o = port_sck_o;
  assign pad_ws_o  = port_ws_o;

endmodule

// File: tb/tb_i2s_clkws_gen_multi.sv
// Randomised bench for i2s_clkws_gen_multi against an arithmetic waveform model.
module tb_i2s_clkws_gen_multi;

  localparam int NG  = 2;
  localparam int NP  = 2;
  localparam int DW  = 16;
  localparam int SW  = 5;
  localparam int NW  = 3;
  localparam int SS  = 2;
  localparam int SLW = 1;

  logic              clk_i = 1'b0;
  logic              rstn_i;
  logic [NG-1:0]     cfg_en_i;
  logic [NG*DW-1:0]  cfg_div_i;
  logic [NG*SW-1:0]  cfg_word_size_i;
  logic [NG*NW-1:0]  cfg_word_num_i;
  logic [NG*2-1:0]   cfg_ws_mode_i;
  logic [NP-1:0]     port_en_i;
  logic [NP*SLW-1:0] port_sel_num_i;
  logic [NP-1:0]     port_sel_ext_i;
  logic [NP-1:0]     pad_sck_i;
  logic [NP-1:0]     pad_ws_i;
  logic [NP-1:0]     pad_sck_o;
  logic [NP-1:0]     pad_ws_o;
  logic [NP-1:0]     pad_oe_o;
  logic [NP-1:0]     port_sck_o;
  logic [NP-1:0]     port_ws_o;
  logic [NP-1:0]     port_rise_o;
  logic [NP-1:0]     port_fall_o;
  logic [NG-1:0]     gen_frame_start_o;

  int checks = 0;
  int errors = 0;
  int m_div[NG];
  int m_size[NG];
  int m_num[NG];
  int m_mode[NG];

  always #5 clk_i = ~clk_i;

  i2s_clkws_gen_multi #(
    .NUM_GEN(NG), .NUM_PORT(NP), .DIV_W(DW), .SIZE_W(SW), .NUM_W(NW), .SYNC_STAGES(SS)
  ) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .cfg_en_i(cfg_en_i), .cfg_div_i(cfg_div_i),
    .cfg_word_size_i(cfg_word_size_i), .cfg_word_num_i(cfg_word_num_i),
    .cfg_ws_mode_i(cfg_ws_mode_i), .port_en_i(port_en_i), .port_sel_num_i(port_sel_num_i),
    .port_sel_ext_i(port_sel_ext_i), .pad_sck_i(pad_sck_i), .pad_ws_i(pad_ws_i),
    .pad_sck_o(pad_sck_o), .pad_ws_o(pad_ws_o), .pad_oe_o(pad_oe_o),
    .port_sck_o(port_sck_o), .port_ws_o(port_ws_o), .port_rise_o(port_rise_o),
    .port_fall_o(port_fall_o), .gen_frame_start_o(gen_frame_start_o)
  );

  task automatic check(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Generator waveform t clocks after it became active: {sck, ws, rise, fall, frame_start}.
  function automatic logic [4:0] gen_ref(input int t, input int div, input int size,
                                         input int num, input int mode);
    int half, tog, falls, bits, pos;
    logic sck, ws, rise, fall, fs, edg;
    half  = div + 1;
    tog   = t / half;
    edg   = (t > 0) && (t % half == 0);
    sck   = (tog % 2) == 1;
    rise  = edg && sck;
    fall  = edg && !sck;
    falls = tog / 2;
    bits  = (size + 1) * (num + 1);
    pos   = falls % bits;
    fs    = fall && (pos == 0);
    if (mode == 1) ws = (falls > 0) && (pos == bits - 1);
    else           ws = ((falls / (size + 1)) % 2) == 1;
    return {sck, ws, rise, fall, fs};
  endfunction

  task automatic set_gen(input int g, input int div, input int size, input int num, input int mode);
    m_div[g] = div; m_size[g] = size; m_num[g] = num; m_mode[g] = mode;
    cfg_div_i[g*DW +: DW]       = DW'(div);
    cfg_word_size_i[g*SW +: SW] = SW'(size);
    cfg_word_num_i[g*NW +: NW]  = NW'(num);
    cfg_ws_mode_i[g*2 +: 2]     = 2'(mode);
  endtask

  task automatic start_int(input int g, input bit dual);
    cfg_en_i[g]               = 1'b1;
    port_en_i[0]              = 1'b1;
    port_sel_ext_i[0]         = 1'b0;
    port_sel_num_i[0 +: SLW]  = SLW'(g);
    if (dual) begin
      port_en_i[1]              = 1'b1;
      port_sel_ext_i[1]         = 1'b0;
      port_sel_num_i[SLW +: SLW] = SLW'(g);
    end
  endtask

  task automatic run_int(input int g, input int cycles, input bit dual, inout int t);
    logic [4:0] pe, ge;
    repeat (cycles) begin
      @(posedge clk_i); t++; @(negedge clk_i);
      pe = gen_ref(t - 1, m_div[g], m_size[g], m_num[g], m_mode[g]);
      ge = gen_ref(t, m_div[g], m_size[g], m_num[g], m_mode[g]);
      check("p0_sck", port_sck_o[0], pe[4]);
      check("p0_ws", port_ws_o[0], pe[3]);
      check("p0_rise", port_rise_o[0], pe[2]);
      check("p0_fall", port_fall_o[0], pe[1]);
      check("pad_sck0", pad_sck_o[0], pe[4]);
      check("pad_ws0", pad_ws_o[0], pe[3]);
      check("oe0", pad_oe_o[0], 1'b1);
      check("fs_sel", gen_frame_start_o[g], ge[0]);
      check("fs_other", gen_frame_start_o[1-g], 1'b0);
      if (dual) begin
        check("p1_sck", port_sck_o[1], pe[4]);
        check("p1_ws", port_ws_o[1], pe[3]);
        check("p1_rise_eq", port_rise_o[1], port_rise_o[0]);
        check("p1_fall_eq", port_fall_o[1], port_fall_o[0]);
      end
    end
  endtask

  task automatic check_ports_zero(input string tag);
    for (int p = 0; p < NP; p++) begin
      check({tag, "_sck"}, port_sck_o[p], 1'b0);
      check({tag, "_ws"}, port_ws_o[p], 1'b0);
      check({tag, "_rise"}, port_rise_o[p], 1'b0);
      check({tag, "_fall"}, port_fall_o[p], 1'b0);
    end
  endtask

  task automatic idle();
    cfg_en_i = '0; port_en_i = '0; port_sel_ext_i = '0;
    @(posedge clk_i); @(negedge clk_i);
    check("idle_fs0", gen_frame_start_o[0], 1'b0);
    check("idle_fs1", gen_frame_start_o[1], 1'b0);
    check("idle_oe0", pad_oe_o[0], 1'b0);
    @(posedge clk_i); @(negedge clk_i);
    check_ports_zero("idle");
  endtask

  initial begin
    int t, g;
    logic ps[0:1023];
    logic pw[0:1023];
    logic cs, cw;
    int rem;

    rstn_i = 1'b0; cfg_en_i = '0; cfg_div_i = '0; cfg_word_size_i = '0;
    cfg_word_num_i = '0; cfg_ws_mode_i = '0; port_en_i = '0; port_sel_num_i = '0;
    port_sel_ext_i = '0; pad_sck_i = '0; pad_ws_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check_ports_zero("rst");
    check("rst_oe0", pad_oe_o[0], 1'b0);
    check("rst_fs0", gen_frame_start_o[0], 1'b0);
    rstn_i = 1'b1;

    // Word mode, div=1: 4-clk SCK, frame every 128 clk.
    set_gen(0, 1, 15, 1, 0); start_int(0, 0); t = 0;
    run_int(0, 300, 0, t);
    idle();

    // div=0: SCK toggles every clock, first toggle right after enable.
    set_gen(0, 0, 7, 1, 0); start_int(0, 0); t = 0;
    run_int(0, 100, 0, t);
    idle();

    // TDM on generator 1: one-bit WS pulse before each 256-bit frame.
    set_gen(1, 2, 31, 7, 1); start_int(1, 0); t = 0;
    run_int(1, 1700, 0, t);
    idle();

    for (int k = 0; k < 6; k++) begin
      g = $urandom_range(0, 1);
      set_gen(g, $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 3));
      start_int(g, 0); t = 0;
      run_int(g, 4 * (m_div[g] + 1) * (m_size[g] + 1) * (m_num[g] + 1) + 20, 0, t);
      idle();
    end

    // Drop the generator enable in the middle of word 3, then restart.
    set_gen(0, 1, 15, 3, 0); start_int(0, 0); t = 0;
    run_int(0, 213, 0, t);
    cfg_en_i[0] = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    check("drop_fs0", gen_frame_start_o[0], 1'b0);
    @(posedge clk_i); @(negedge clk_i);
    check_ports_zero("drop");
    @(posedge clk_i); @(negedge clk_i);
    check_ports_zero("drop2");
    cfg_en_i[0] = 1'b1; t = 0;
    run_int(0, 300, 0, t);
    idle();

    // Two ports on one generator, with a reset pulse mid-frame.
    set_gen(0, 2, 7, 3, 1); start_int(0, 1); t = 0;
    run_int(0, 150, 1, t);
    rstn_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    check_ports_zero("midrst");
    check("midrst_oe0", pad_oe_o[0], 1'b0);
    check("midrst_fs0", gen_frame_start_o[0], 1'b0);
    rstn_i = 1'b1; t = 0;
    run_int(0, 250, 1, t);
    idle();

    // External pads on port 1.
    port_en_i[1] = 1'b1; port_sel_ext_i[1] = 1'b1; port_sel_num_i[SLW +: SLW] = SLW'(1);
    for (int i = 0; i < 1024; i++) begin ps[i] = 1'b0; pw[i] = 1'b0; end
    cs = 1'b0; cw = 1'b0; rem = 5;
    for (int e = 1; e <= 400; e++) begin
      rem--;
      if (rem == 0) begin
        cs = ~cs;
        if (!cs && ($urandom_range(0, 1) == 1)) cw = ~cw;
        rem = (e < 150) ? 5 : $urandom_range(2, 6);
      end
      pad_sck_i[1] = cs; pad_ws_i[1] = cw;
      pad_sck_i[0] = 1'($urandom_range(0, 1));
      pad_ws_i[0]  = 1'($urandom_range(0, 1));
      ps[e+3] = cs; pw[e+3] = cw;
      @(posedge clk_i); @(negedge clk_i);
      check("x_sck", port_sck_o[1], ps[e+1]);
      check("x_ws", port_ws_o[1], pw[e+1]);
      check("x_rise", port_rise_o[1], ps[e+1] & ~ps[e]);
      check("x_fall", port_fall_o[1], ~ps[e+1] & ps[e]);
      check("x_pad_sck1", pad_sck_o[1], ps[e+1]);
      check("x_oe1", pad_oe_o[1], 1'b0);
      check("x_p0_sck", port_sck_o[0], 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_clkws_gen_multi.md
Name: i2s_clkws_gen_multi

Overview:
Single-clock, parametrised successor of the I2S SCK/WS generator. It contains NUM_GEN divider-based SCK/WS generators and NUM_PORT I2S ports. Each port selects an internal generator or an external pad pair, and every output is a registered level or strobe in the clk_i domain; no gated or muxed clocks are produced. The block adds a TDM/DSP pulse WS mode, frame-start strobes and automatic generator enable, and feeds the uDMA I2S RX/TX channels, which shift data on the rise/fall strobes.

Parameters:
NUM_GEN, 2, number of internal SCK/WS generators
NUM_PORT, 2, number of I2S ports/pad pairs
DIV_W, 16, divider width
SIZE_W, 5, word size field; bits per word = cfg+1
NUM_W, 3, word count field; words per frame = cfg+1
SYNC_STAGES, 2, pad synchroniser depth (>=2)
SEL_W, max(1,$clog2(max(NUM_GEN,NUM_PORT))), derived source-select width

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset
cfg_en_i  in  NUM_GEN  generator enable
cfg_div_i  in  NUM_GEN*DIV_W  half-period minus 1, per generator
cfg_word_size_i  in  NUM_GEN*SIZE_W  bits per word minus 1
cfg_word_num_i  in  NUM_GEN*NUM_W  words per frame minus 1
cfg_ws_mode_i  in  NUM_GEN*2  WS mode (ws_mode_e)
port_en_i  in  NUM_PORT  port enable
port_sel_num_i  in  NUM_PORT*SEL_W  source index (generator or pad)
port_sel_ext_i  in  NUM_PORT  1 = external pads
pad_sck_i / pad_ws_i  in  NUM_PORT  pad inputs, asynchronous
pad_sck_o / pad_ws_o  out  NUM_PORT  pad drive = port_sck_o/port_ws_o
pad_oe_o  out  NUM_PORT  port_en & ~port_sel_ext
port_sck_o / port_ws_o  out  NUM_PORT  selected SCK level / WS
port_rise_o / port_fall_o  out  NUM_PORT  1-cycle SCK edge strobes
gen_frame_start_o  out  NUM_GEN  1-cycle strobe at frame start

Behaviour:
- Interface: one clock, clk_i; reset rstn_i is synchronous and active-low.
- Reset: all outputs and state are 0; sck=0, ws=0, counters=0.
- Generator g is active when cfg_en_i[g] is high and at least one enabled, internal port selects g.
- Divider:
  - cnt counts 0..div; at cnt==div, sck toggles and cnt returns to 0. Half-period is div+1 clk, so div=0 gives clk/2.
  - cfg_div is sampled only at wrap, so a change takes effect on the next half-period.
  - rise/fall strobes are asserted in the same cycle the registered sck changes.
- Bit/word counters advance on each sck fall strobe.
  - bit_cnt runs 0..size; at wrap, word_cnt runs 0..num.
  - When both wrap to 0, gen_frame_start pulses for that cycle.
  - size and num are sampled at frame start.
- WS, updated on the fall strobe:
  - mode 00 WORD: ws toggles when bit_cnt wraps.
  - mode 01 TDM: ws=1 only during the last bit of the frame, i.e. one bit before frame start.
  - modes 10/11: reserved; behave as 00.
- Inactive generator: next cycle, sck=0, ws=0, cnt/bit/word=0, no strobes. Re-enable restarts at word 0, bit 0, with the first toggle after div+1 cycles.
- External source:
  - pad_sck_i and pad_ws_i each pass through SYNC_STAGES flops plus one history flop.
  - rise = sync & ~hist, fall = ~sync & hist.
  - pad_ws goes through identical depth so SCK/WS alignment is preserved.
  - Valid only when pad SCK half-period >= 2 clk.
- Port mux: internal uses generator[sel]; external uses pad[sel] synced.
  - Out-of-range sel drives the port outputs to 0.
  - Port outputs are registered: 1 clk after the generator/sync signal.
- port_en=0: port_sck, ws, rise, fall = 0 on the next cycle; pad_oe=0.
- Changing sel or sel_ext mid-frame is allowed, but the first resulting edge may be glitched. Software must disable the port first.
- Two ports selecting the same source produce cycle-identical outputs.
- Reset asserted mid-operation: all state returns to reset values in the next cycle.

Decomposition:
- Package i2s_clkws_pkg:
  - ws_mode_e (WS_WORD=2'b00, WS_TDM=2'b01).
  - Default widths DIV_W/SIZE_W/NUM_W.
  - Function sel_w().
- Sub-module i2s_sck_ws_core: one generator (divider, bit/word counters, WS modes, frame strobe), instantiated NUM_GEN times.
- Pad sync and port mux stay in the top level.

Test Plan:
- Port0 internal gen0: div=1, size=15, num=1, mode 00.
  - sck period is 4 clk.
  - ws toggles every 16 falls.
  - frame_start every 128 clk.
  - port outputs lag generator by 1 clk.
- Port0 internal gen0: div=0.
  - sck toggles every clk.
  - rise/fall strobes alternate every cycle.
  - first toggle 1 clk after enable.
- Gen1 TDM: size=31, num=7, div=2.
  - ws high for exactly 6 clk (1 bit) every 256 bits.
  - ws falls coincident with frame_start.
- Port1 external, sel=1: pad_sck toggles every 5 clk.
  - port_rise_o pulses SYNC_STAGES+1 clk after the pad edge.
  - pad_oe_o[1]=0.
  - pad_ws is aligned to the same edge.
- cfg_en_i[0] dropped mid-word 3.
  - Next cycle: sck=0, ws=0, no strobes.
  - Re-enable: frame_start at the first fall with bit 0, word 0.
- rstn_i low mid-frame with two ports on gen0.
  - All outputs are 0 the next cycle.
  - After release, both ports are identical cycle-for-cycle.
